// File: rtl/timer_dev_if.sv
// Bus port between the system bridge and the timer_dev responder.
// Writes are single-cycle: WE (already gated by the bridge device hit) qualifies Addr/Din at the rising clk edge; reads have no handshake because Dout is combinational from Addr[3:2] every cycle.
interface timer_dev_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic [1:0]  state_dbg;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout,
        input  IRQ,
        input  state_dbg
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout,
        output IRQ,
        output state_dbg
    );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable IRQ.
// Optional TIMER_STATUS_EN exposes {state, irq_pend} as a read-only STATUS word at offset 3.
module timer_dev #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000,
    parameter logic [3:0]  CTRL_RST   = 4'h0
) (
    input logic        clk,
    input logic        reset_n,
    timer_dev_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [3:0]  ctrl, ctrl_n, ctrl_cur;
    logic [31:0] preset, preset_n;
    logic [31:0] count, count_n;
    logic        irq_pend, irq_pend_n;
    logic        irq, irq_n;
    logic        ctrl_wr, preset_wr;
    logic [1:0]  offset;
    logic        unused_addr;

    assign offset      = bus.Addr[3:2];
    assign unused_addr = ^bus.Addr[31:4];
    assign ctrl_wr     = bus.WE && (offset == 2'd0);
    assign preset_wr   = bus.WE && (offset == 2'd1);

    // The FSM sees CTRL as it will be after a write on this same edge.
    assign ctrl_cur = ctrl_wr ? bus.Din[3:0] : ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ctrl     <= CTRL_RST;
            preset   <= PRESET_RST;
            count    <= 32'h0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_n;
            ctrl     <= ctrl_n;
            preset   <= preset_n;
            count    <= count_n;
            irq_pend <= irq_pend_n;
            irq      <= irq_n;
        end
    end

    always_comb begin
        state_n    = state;
        ctrl_n     = ctrl_cur;
        preset_n   = preset_wr ? bus.Din : preset;
        count_n    = count;
        irq_pend_n = irq_pend;

        case (state)
            S_IDLE: begin
                if (ctrl_cur[0]) state_n = S_LOAD;
            end
            S_LOAD: begin
                if (!ctrl_cur[0]) begin
                    state_n = S_IDLE;
                end else begin
                    count_n = preset;
                    state_n = S_CNT;
                end
            end
            S_CNT: begin
                if (!ctrl_cur[0]) begin
                    state_n = S_IDLE;
                end else if (count > 32'd1) begin
                    count_n = count - 32'd1;
                end else begin
                    count_n    = 32'h0;
                    irq_pend_n = 1'b1;
                    state_n    = S_INT;
                end
            end
            S_INT: begin
                if (ctrl_cur[0] && (ctrl_cur[2:1] == 2'd1)) begin
                    irq_pend_n = 1'b0;
                    state_n    = S_LOAD;
                end else begin
                    state_n = S_IDLE;
                    // A software write of EN on this edge overrides the one-shot EN clear.
                    if (!ctrl_wr) ctrl_n[0] = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (ctrl_wr || preset_wr) irq_pend_n = 1'b0;
    end

    assign irq_n = irq_pend_n & ctrl_n[3];

    always_comb begin
        bus.Dout = 32'h0;
        case (offset)
            2'd0: bus.Dout = {28'h0, ctrl};
            2'd1: bus.Dout = preset;
            2'd2: bus.Dout = count;
`ifdef TIMER_STATUS_EN
            2'd3: bus.Dout = {29'h0, state, irq_pend};
`else
            2'd3: bus.Dout = 32'h0;
`endif
            default: bus.Dout = 32'h0;
        endcase
    end

    assign bus.IRQ       = irq;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register map, one-shot, reload, masking, mid-count writes, edge presets, reset.
module tb_timer_dev;

    localparam logic [31:2] BASE = 30'h0000_1FC0;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    timer_dev_if bus ();

    timer_dev dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
        bus.Addr = BASE + 30'(off);
        bus.WE   = 1'b1;
        bus.Din  = d;
        @(negedge clk);
        bus.WE   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        bus.Addr = BASE + 30'(off);
        #1;
        check(tag, bus.Dout, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        check(tag, 32'(bus.IRQ), 32'(exp));
    endtask

    logic [31:0] m1_count [8] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0};
    logic        m1_irq   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        bus.Addr = BASE;
        bus.WE   = 1'b0;
        bus.Din  = 32'h0;
        #1;
        read_chk("rst_ctrl", 2'd0, 32'h0);
        read_chk("rst_preset", 2'd1, 32'h0);
        read_chk("rst_count", 2'd2, 32'h0);
        read_chk("rst_off3", 2'd3, 32'h0);
        irq_chk("rst_irq", 1'b0);
        check("rst_state", 32'(bus.state_dbg), 32'h0);
        step(2);
        reset_n = 1'b1;
        step(1);

        // Mode 0 one-shot, PRESET=3
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h9);
        step(1); read_chk("m0_cnt3", 2'd2, 32'd3);
        step(1); read_chk("m0_cnt2", 2'd2, 32'd2);
        step(1); read_chk("m0_cnt1", 2'd2, 32'd1);
        irq_chk("m0_irq_pre", 1'b0);
        step(1); read_chk("m0_cnt0", 2'd2, 32'd0);
        irq_chk("m0_irq_rise", 1'b1);
        step(1); read_chk("m0_ctrl_en_clr", 2'd0, 32'h8);
        irq_chk("m0_irq_hold", 1'b1);
        step(2); irq_chk("m0_irq_sticky", 1'b1);
        bus_write(2'd0, 32'h0);
        irq_chk("m0_irq_clr", 1'b0);

        // Mode 1 auto-reload, PRESET=2
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);
        for (int k = 0; k < 8; k++) begin
            step(1);
            read_chk($sformatf("m1_count_%0d", k), 2'd2, m1_count[k]);
            irq_chk($sformatf("m1_irq_%0d", k), m1_irq[k]);
        end
        bus_write(2'd0, 32'h0);
        irq_chk("m1_stop_irq", 1'b0);

        // Masked interrupt
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h1);
        step(2);
        read_chk("mask_cnt0", 2'd2, 32'd0);
        irq_chk("mask_irq", 1'b0);
`ifdef TIMER_STATUS_EN
        read_chk("mask_status_int", 2'd3, 32'h7);
`else
        read_chk("mask_off3", 2'd3, 32'h0);
`endif
        step(1);
        irq_chk("mask_irq_idle", 1'b0);
        read_chk("mask_ctrl", 2'd0, 32'h0);
`ifdef TIMER_STATUS_EN
        read_chk("mask_status_idle", 2'd3, 32'h1);
`else
        read_chk("mask_off3_idle", 2'd3, 32'h0);
`endif

        // Disable and writes mid-count
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h1);
        step(5);
        read_chk("dis_cnt6", 2'd2, 32'd6);
        bus_write(2'd0, 32'h0);
        read_chk("dis_hold", 2'd2, 32'd6);
        step(2);
        read_chk("dis_hold2", 2'd2, 32'd6);
        irq_chk("dis_irq", 1'b0);
        bus_write(2'd2, 32'h1234);
        read_chk("dis_count_ro", 2'd2, 32'd6);
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_chk("dis_off3_wr_ctrl", 2'd0, 32'h0);
        read_chk("dis_off3_wr_preset", 2'd1, 32'd10);
        bus_write(2'd0, 32'h1);
        step(1);
        read_chk("dis_reload", 2'd2, 32'd10);
        bus_write(2'd0, 32'h0);

        // CTRL write in the INT cycle: software EN wins over the one-shot clear
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h9);
        step(2);
        irq_chk("int_wr_irq", 1'b1);
        bus_write(2'd0, 32'h9);
        read_chk("int_wr_ctrl", 2'd0, 32'h9);
        irq_chk("int_wr_irq_clr", 1'b0);
        step(2);
        read_chk("int_wr_reload", 2'd2, 32'd1);
        step(1);
        irq_chk("int_wr_irq2", 1'b1);
        bus_write(2'd0, 32'h0);

        // PRESET=0
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        step(1);
        irq_chk("p0_irq_load", 1'b0);
        step(1);
        irq_chk("p0_irq", 1'b1);
        read_chk("p0_cnt", 2'd2, 32'd0);
        bus_write(2'd0, 32'h0);

        // PRESET=max, then PRESET write during CNT
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'h1);
        step(1); read_chk("pmax_load", 2'd2, 32'hFFFF_FFFF);
        step(1); read_chk("pmax_dec", 2'd2, 32'hFFFF_FFFE);
        bus_write(2'd1, 32'd5);
        read_chk("pwr_cnt_unaffected", 2'd2, 32'hFFFF_FFFD);
        read_chk("pwr_preset", 2'd1, 32'd5);
        bus_write(2'd0, 32'h0);
        bus_write(2'd0, 32'h1);
        step(1);
        read_chk("pwr_next_load", 2'd2, 32'd5);
        bus_write(2'd0, 32'h0);

        // Reset mid-count
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        step(6);
        read_chk("rmid_cnt5", 2'd2, 32'd5);
        reset_n = 1'b0;
        read_chk("rmid_ctrl", 2'd0, 32'h0);
        read_chk("rmid_preset", 2'd1, 32'h0);
        read_chk("rmid_count", 2'd2, 32'h0);
        irq_chk("rmid_irq", 1'b0);
        step(2);
        irq_chk("rmid_irq_held", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
